// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB requester.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  function automatic int unsigned strb_w(int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned APB_ADDR_W = 12;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = strb_w(APB_DATA_W);

  // Command as seen on the request side, at the default bus widths.
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timeout.sv
// Counts ACCESS wait cycles and flags the last wait cycle allowed before an abort.
module apb_wait_timeout #(
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // High during the TIMEOUT-th wait cycle; never fires when TIMEOUT is 0.
  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_requester.sv
// Single-outstanding command/response to APB3/APB4 requester with wait-state timeout.
module apb_master_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned STRB_W = strb_w(DATA_W)
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic [STRB_W-1:0] PSTRB,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  apb_state_e        state_q, state_d;
  cmd_t              cmd_q;
  logic              accept;
  logic              complete;
  logic              abort;
  logic              expired;
  logic              cnt_clr;
  logic              cnt_en;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // Completion wins over a timeout landing in the same cycle.
        if (PREADY) begin
          complete  = 1'b1;
          cmd_ready = 1'b1;
          state_d   = cmd_valid ? SETUP : IDLE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept  = cmd_valid && cmd_ready;
  assign cnt_clr = accept;
  assign cnt_en  = (state_q == ACCESS) && !PREADY;

  apb_wait_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timeout (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transfer attributes are captured once and held across the transfer and idle time.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cmd_q <= '0;
    end else if (accept) begin
      cmd_q.write <= cmd_write;
      cmd_q.addr  <= cmd_addr;
      cmd_q.wdata <= cmd_wdata;
      cmd_q.strb  <= cmd_write ? cmd_strb : '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      rsp_valid_q   <= complete || abort;
      rsp_err_q     <= complete ? PSLVERR : abort;
      rsp_timeout_q <= abort;
      rsp_rdata_q   <= (complete && !cmd_q.write) ? PRDATA : '0;
    end
  end

  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = cmd_q.addr;
  assign PWRITE      = cmd_q.write;
  assign PWDATA      = cmd_q.wdata;
  assign PSTRB       = cmd_q.strb;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule
